// File: rtl/fir_pkg.sv
// fir_pkg: shared types and helpers for the FIR MAC scheduler.
//   - fir_sched_state_t : scheduler FSM states
//   - FIR_* constants   : default parameter values for the scheduler and its interface
//   - saturate()        : clamps a signed value to a w-bit two's-complement range
package fir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT,
        ST_CAPTURE,
        ST_OUTPUT
    } fir_sched_state_t;

    localparam int FIR_WIDTH       = 8;
    localparam int FIR_NUM_TAPS    = 32;
    localparam int FIR_ACC_WIDTH   = 24;
    localparam int FIR_MAC_LATENCY = 2;
    localparam int FIR_SHIFT       = 10;

    // Works on 32-bit signed values so any accumulator up to 32 bits can be
    // sign-extended in and the result truncated back to w bits by the caller.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                    input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// fir_mac_scheduler_if: bundles the sample input, MAC drive/return and the
// filtered-result handshake of the FIR MAC scheduler.
//   master : the scheduler (drives MAC controls, result, busy/overrun)
//   slave  : the surrounding system (sample source, MAC, downstream sink)
interface fir_mac_scheduler_if import fir_pkg::*; #(
    parameter int WIDTH     = FIR_WIDTH,
    parameter int NUM_TAPS  = FIR_NUM_TAPS,
    parameter int ACC_WIDTH = FIR_ACC_WIDTH
);
    logic signed [WIDTH-1:0]            sample_in;
    logic                               sample_valid_in;
    logic signed [WIDTH-1:0]            mac_sample_out;
    logic [$clog2(NUM_TAPS)-1:0]        mac_coef_addr_out;
    logic                               mac_en_out;
    logic                               mac_clear_out;
    logic signed [ACC_WIDTH-1:0]        mac_acc_in;
    logic signed [WIDTH-1:0]            filtered_out;
    logic                               filtered_valid_out;
    logic                               filtered_ready_in;
    logic                               busy_out;
    logic                               overrun_out;

    modport master (
        input  sample_in, sample_valid_in, mac_acc_in, filtered_ready_in,
        output mac_sample_out, mac_coef_addr_out, mac_en_out, mac_clear_out,
               filtered_out, filtered_valid_out, busy_out, overrun_out
    );

    modport slave (
        output sample_in, sample_valid_in, mac_acc_in, filtered_ready_in,
        input  mac_sample_out, mac_coef_addr_out, mac_en_out, mac_clear_out,
               filtered_out, filtered_valid_out, busy_out, overrun_out
    );
endinterface

// File: rtl/fir_delay_line.sv
// fir_delay_line: circular buffer of the last NUM_TAPS samples.
//   clk_i, rst_n_i : clock, synchronous active-low clear of every entry
//   wr_en_i        : write wr_data_i to entry wptr_i
//   rd_off_i       : read entry (wptr_i - rd_off_i) mod NUM_TAPS
//   rd_data_o      : combinational read data, write-first when the read hits
//                    the entry being written this cycle
module fir_delay_line import fir_pkg::*; #(
    parameter int WIDTH    = FIR_WIDTH,
    parameter int NUM_TAPS = FIR_NUM_TAPS,
    parameter int AW       = $clog2(NUM_TAPS)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    wr_en_i,
    input  logic [AW-1:0]           wptr_i,
    input  logic signed [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]           rd_off_i,
    output logic signed [WIDTH-1:0] rd_data_o
);
    logic signed [WIDTH-1:0] mem_q [NUM_TAPS];
    logic [AW-1:0]           rd_addr;

    // NUM_TAPS is a power of two, so AW-bit subtraction is the modulo wrap.
    always_comb begin
        rd_addr   = wptr_i - rd_off_i;
        rd_data_o = (wr_en_i && (rd_addr == wptr_i)) ? wr_data_i : mem_q[rd_addr];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_TAPS; i++) mem_q[i] <= '0;
        end else if (wr_en_i) begin
            mem_q[wptr_i] <= wr_data_i;
        end
    end
endmodule

// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler: sequences a shared single-multiplier FIR MAC, one tap
// per clock, then scales/saturates the accumulator and hands the result
// downstream with valid/ready.
//   clk_in : system clock
//   rst_in : synchronous active-low reset (aborts any run in progress)
//   bus    : fir_mac_scheduler_if.master -- sample strobe, MAC drive
//            (sample, coefficient address, enable, clear), accumulator return,
//            filtered result handshake, busy and overrun flags
module fir_mac_scheduler import fir_pkg::*; #(
    parameter int WIDTH       = FIR_WIDTH,
    parameter int NUM_TAPS    = FIR_NUM_TAPS,
    parameter int ACC_WIDTH   = FIR_ACC_WIDTH,
    parameter int MAC_LATENCY = FIR_MAC_LATENCY,
    parameter int SHIFT       = FIR_SHIFT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    fir_mac_scheduler_if.master  bus
);
    localparam int AW = $clog2(NUM_TAPS);
    localparam int WW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    fir_sched_state_t        state_q, state_d;
    logic [AW-1:0]           k_q, k_d;
    logic [WW-1:0]           wait_q, wait_d;
    logic [AW-1:0]           wptr_q, wptr_d;
    logic signed [WIDTH-1:0] mac_sample_q, mac_sample_d;
    logic [AW-1:0]           coef_q, coef_d;
    logic                    en_q, en_d;
    logic                    clr_q, clr_d;
    logic signed [WIDTH-1:0] filt_q, filt_d;
    logic                    fvld_q, fvld_d;
    logic                    busy_q, busy_d;
    logic                    ovr_q, ovr_d;

    logic                        dl_wr_en;
    logic [AW-1:0]               dl_rd_off;
    logic signed [WIDTH-1:0]     dl_rd_data;
    logic signed [ACC_WIDTH-1:0] acc_shifted;

    fir_delay_line #(
        .WIDTH    (WIDTH),
        .NUM_TAPS (NUM_TAPS),
        .AW       (AW)
    ) u_delay_line (
        .clk_i     (clk_in),
        .rst_n_i   (rst_in),
        .wr_en_i   (dl_wr_en),
        .wptr_i    (wptr_q),
        .wr_data_i (bus.sample_in),
        .rd_off_i  (dl_rd_off),
        .rd_data_o (dl_rd_data)
    );

    assign acc_shifted = bus.mac_acc_in >>> SHIFT;

    // MAC outputs are registered one cycle ahead: the cycle that decides tap k
    // loads it, so mac_en_out is high exactly while the FSM sits in RUN.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        wait_d       = wait_q;
        wptr_d       = wptr_q;
        mac_sample_d = mac_sample_q;
        coef_d       = coef_q;
        en_d         = 1'b0;
        clr_d        = 1'b0;
        filt_d       = filt_q;
        fvld_d       = fvld_q;
        ovr_d        = bus.sample_valid_in && (state_q != ST_IDLE);
        dl_wr_en     = 1'b0;
        dl_rd_off    = k_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (bus.sample_valid_in) begin
                    dl_wr_en     = 1'b1;
                    dl_rd_off    = '0;
                    mac_sample_d = dl_rd_data;
                    coef_d       = '0;
                    en_d         = 1'b1;
                    clr_d        = 1'b1;
                    k_d          = '0;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (k_q == AW'(NUM_TAPS - 1)) begin
                    wait_d  = '0;
                    state_d = ST_WAIT;
                end else begin
                    k_d          = k_q + 1'b1;
                    coef_d       = k_q + 1'b1;
                    mac_sample_d = dl_rd_data;
                    en_d         = 1'b1;
                end
            end
            ST_WAIT: begin
                if (wait_q == WW'(MAC_LATENCY - 1)) state_d = ST_CAPTURE;
                else                                wait_d  = wait_q + 1'b1;
            end
            ST_CAPTURE: begin
                filt_d  = WIDTH'(saturate(32'(acc_shifted), WIDTH));
                fvld_d  = 1'b1;
                state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (bus.filtered_ready_in) begin
                    fvld_d  = 1'b0;
                    wptr_d  = wptr_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            wait_q       <= '0;
            wptr_q       <= '0;
            mac_sample_q <= '0;
            coef_q       <= '0;
            en_q         <= 1'b0;
            clr_q        <= 1'b0;
            filt_q       <= '0;
            fvld_q       <= 1'b0;
            busy_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            wait_q       <= wait_d;
            wptr_q       <= wptr_d;
            mac_sample_q <= mac_sample_d;
            coef_q       <= coef_d;
            en_q         <= en_d;
            clr_q        <= clr_d;
            filt_q       <= filt_d;
            fvld_q       <= fvld_d;
            busy_q       <= busy_d;
            ovr_q        <= ovr_d;
        end
    end

    assign bus.mac_sample_out     = mac_sample_q;
    assign bus.mac_coef_addr_out  = coef_q;
    assign bus.mac_en_out         = en_q;
    assign bus.mac_clear_out      = clr_q;
    assign bus.filtered_out       = filt_q;
    assign bus.filtered_valid_out = fvld_q;
    assign bus.busy_out           = busy_q;
    assign bus.overrun_out        = ovr_q;
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb_fir_mac_scheduler: directed bench for fir_mac_scheduler with a
// behavioural 2-cycle MAC + coefficient ROM and a result scoreboard.
// dut0 runs with SHIFT=0; dut1 (SHIFT=10) shares all stimulus but always
// sees an accumulator of 0x0FFC00.
module tb_fir_mac_scheduler;
    localparam int W  = 8;
    localparam int N  = 32;
    localparam int AC = 24;
    localparam int L  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic signed [W-1:0] smp;
    logic             svld;
    logic             rdy;

    fir_mac_scheduler_if #(.WIDTH(W), .NUM_TAPS(N), .ACC_WIDTH(AC)) if0 ();
    fir_mac_scheduler_if #(.WIDTH(W), .NUM_TAPS(N), .ACC_WIDTH(AC)) if1 ();

    fir_mac_scheduler #(.WIDTH(W), .NUM_TAPS(N), .ACC_WIDTH(AC), .MAC_LATENCY(L), .SHIFT(0))
        dut0 (.clk_in(clk), .rst_in(rst), .bus(if0));
    fir_mac_scheduler #(.WIDTH(W), .NUM_TAPS(N), .ACC_WIDTH(AC), .MAC_LATENCY(L), .SHIFT(10))
        dut1 (.clk_in(clk), .rst_in(rst), .bus(if1));

    int n_tests = 0;
    int n_fail  = 0;
    int rom [N];
    int hist [N];
    int expq [$];
    bit force_en;
    int force_val;
    int exp_k = 0;

    int coef_tab [N] = '{18, -185, 26, -3, 40, 127, 128, -128, -129, 300, -7, 0, 5, 64, -64, 99,
                         100, -100, 1, -1, 77, -77, 12, -12, 250, -250, 33, -33, 8, -8, 2, -2};

    // Behavioural MAC: product registered, then accumulated -> 2-cycle latency
    int p_prod, acc;
    bit p_en, p_clr;
    logic [AC-1:0] acc_bus;
    always @(posedge clk) begin
        if (!rst) begin
            p_en <= 1'b0; p_clr <= 1'b0; p_prod <= 0; acc <= 0;
        end else begin
            p_en   <= if0.mac_en_out;
            p_clr  <= if0.mac_clear_out;
            p_prod <= int'(if0.mac_sample_out) * rom[if0.mac_coef_addr_out];
            if (p_en) acc <= p_clr ? p_prod : acc + p_prod;
        end
    end
    always_comb acc_bus = force_en ? force_val[AC-1:0] : acc[AC-1:0];

    assign if0.sample_in         = smp;
    assign if0.sample_valid_in   = svld;
    assign if0.filtered_ready_in = rdy;
    assign if0.mac_acc_in        = acc_bus;
    assign if1.sample_in         = smp;
    assign if1.sample_valid_in   = svld;
    assign if1.filtered_ready_in = rdy;
    assign if1.mac_acc_in        = 24'h0FFC00;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Tap sequencing monitor: addresses step 0..N-1, clear only on tap 0
    always @(negedge clk) begin
        if (rst && if0.mac_en_out) begin
            chk("mac_coef_addr", if0.mac_coef_addr_out, exp_k);
            chk("mac_clear", if0.mac_clear_out, (exp_k == 0) ? 1 : 0);
            exp_k <= exp_k + 1;
        end else begin
            exp_k <= 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required to finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic int sat8(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N; i++) hist[i] = 0;
        expq.delete();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (if0.busy_out !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        chk("idle_wait", if0.busy_out, 0);
    endtask

    task automatic wait_k(input int k);
        int n = 0;
        while (!(if0.mac_en_out === 1'b1 && int'(if0.mac_coef_addr_out) == k) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("wait_tap", if0.mac_coef_addr_out, k);
    endtask

    task automatic send_sample(input int x);
        int sum = 0;
        wait_idle();
        smp  = W'(x);
        svld = 1'b1;
        for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = x;
        for (int i = 0; i < N; i++) sum += hist[i] * rom[i];
        expq.push_back(force_en ? sat8(force_val) : sat8(sum));
        @(negedge clk);
        svld = 1'b0;
    endtask

    task automatic get_result(input int hold, input bit ovr);
        int n = 0;
        int e;
        while (if0.filtered_valid_out !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("result_valid", if0.filtered_valid_out, 1);
        e = (expq.size() > 0) ? expq.pop_front() : -999;
        for (int i = 0; i < hold; i++) begin
            chk("bp_valid", if0.filtered_valid_out, 1);
            chk("bp_hold", if0.filtered_out, e);
            @(negedge clk);
        end
        rdy = 1'b1;
        if (ovr) begin smp = 8'sd55; svld = 1'b1; end
        chk("result", if0.filtered_out, e);
        chk("result_shift10", if1.filtered_out, 127);
        @(negedge clk);
        rdy  = 1'b0;
        svld = 1'b0;
        chk("valid_drop", if0.filtered_valid_out, 0);
        chk("busy_after", if0.busy_out, 0);
        if (ovr) chk("overrun_handshake", if0.overrun_out, 1);
        else     chk("no_overrun", if0.overrun_out, 0);
    endtask

    initial begin
        rst = 1'b0; smp = '0; svld = 1'b0; rdy = 1'b0;
        force_en = 1'b0; force_val = 0;
        clear_model();
        rom = coef_tab;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_mac_en", if0.mac_en_out, 0);
        chk("rst_mac_clear", if0.mac_clear_out, 0);
        chk("rst_mac_sample", if0.mac_sample_out, 0);
        chk("rst_coef_addr", if0.mac_coef_addr_out, 0);
        chk("rst_filtered", if0.filtered_out, 0);
        chk("rst_valid", if0.filtered_valid_out, 0);
        chk("rst_busy", if0.busy_out, 0);
        chk("rst_overrun", if0.overrun_out, 0);
        rst = 1'b1;
        @(negedge clk);

        // Impulse response: outputs are the saturated coefficients
        for (int i = 0; i < N; i++) begin
            send_sample((i == 0) ? 1 : 0);
            get_result(0, 1'b0);
        end

        // Ramp-up with all-ones ROM after a fresh reset
        rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
        clear_model();
        for (int i = 0; i < N; i++) rom[i] = 1;
        for (int i = 0; i < N + 1; i++) begin
            send_sample(3);
            get_result(0, 1'b0);
        end

        // Backpressure: ready held low for 10 cycles
        send_sample(7);
        get_result(10, 1'b0);

        // Overrun at tap 10 and on the handshake cycle
        send_sample(-2);
        wait_k(10);
        smp = 8'sd100; svld = 1'b1;
        @(negedge clk);
        svld = 1'b0;
        chk("overrun_run", if0.overrun_out, 1);
        @(negedge clk);
        chk("overrun_pulse_end", if0.overrun_out, 0);
        get_result(0, 1'b1);
        repeat (3) @(negedge clk);
        chk("no_extra_valid", if0.filtered_valid_out, 0);
        chk("no_extra_busy", if0.busy_out, 0);
        send_sample(4);
        get_result(0, 1'b0);

        // Saturation with a forced accumulator
        force_en = 1'b1; force_val = 300;
        send_sample(1);
        get_result(0, 1'b0);
        force_val = -300;
        send_sample(1);
        get_result(0, 1'b0);
        force_en = 1'b0;

        // Reset in the middle of RUN
        send_sample(9);
        wait_k(15);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_mac_en", if0.mac_en_out, 0);
        chk("mid_rst_mac_clear", if0.mac_clear_out, 0);
        chk("mid_rst_mac_sample", if0.mac_sample_out, 0);
        chk("mid_rst_coef_addr", if0.mac_coef_addr_out, 0);
        chk("mid_rst_filtered", if0.filtered_out, 0);
        chk("mid_rst_valid", if0.filtered_valid_out, 0);
        chk("mid_rst_busy", if0.busy_out, 0);
        chk("mid_rst_overrun", if0.overrun_out, 0);
        rst = 1'b1;
        clear_model();
        @(negedge clk);
        send_sample(5);
        get_result(0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
